// File: rtl/aes128_core.sv
// aes128_core: iterative AES-128 cipher, one round per clock; define AES_DECRYPT_EN to build the inverse cipher
module aes128_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE = 2'd0, KEYX = 2'd1, INIT = 2'd2, ROUND = 2'd3;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xt(x);
        end
        return p;
    endfunction
    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction
    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction
    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d, dout_q, dout_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic         done_q, done_d, last;
    logic [7:0]   rcon;
    logic [127:0] nk, rk_sel, init_key, enc_t, enc_out, round_out;
    assign last    = cnt_q == 4'd9;
    assign rcon    = cnt_q < 4'd8 ? 8'h01 << cnt_q : (cnt_q == 4'd8 ? 8'h1b : 8'h36);
    assign nk      = next_key(rk_q[cnt_q], rcon);
    assign enc_t   = shift_rows(sub_bytes(st_q));
    assign enc_out = (last ? enc_t : mix_columns(enc_t)) ^ rk_sel;
`ifdef AES_DECRYPT_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction
    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return o;
    endfunction
    logic         dec_q, dec_d;
    logic [127:0] dec_t;
    assign rk_sel    = dec_q ? rk_q[4'd9 - cnt_q] : rk_q[cnt_q + 4'd1];
    assign init_key  = dec_q ? rk_q[10] : rk_q[0];
    assign dec_t     = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;
    assign round_out = dec_q ? (last ? dec_t : inv_mix_columns(dec_t)) : enc_out;
    assign dec_d     = (state_q == IDLE && start) ? decrypt : dec_q;
    always_ff @(posedge clk) dec_q <= rst ? 1'b0 : dec_d;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign rk_sel    = rk_q[cnt_q + 4'd1];
    assign init_key  = rk_q[0];
    assign round_out = enc_out;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        rk_d    = rk_q;
        if (state_q == IDLE && start) begin
            state_d  = KEYX;
            cnt_d    = 4'd0;
            st_d     = din;
            rk_d[0]  = key;
        end
        if (state_q == KEYX) begin
            for (int k = 1; k < 11; k++) if (cnt_q == 4'(k - 1)) rk_d[k] = nk;
            state_d = last ? INIT : KEYX;
            cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
        end
        if (state_q == INIT) begin
            st_d    = st_q ^ init_key;
            state_d = ROUND;
            cnt_d   = 4'd0;
        end
        if (state_q == ROUND) begin
            st_d    = round_out;
            cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
            state_d = last ? IDLE : ROUND;
            dout_d  = last ? round_out : dout_q;
            done_d  = last;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            st_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end
    always_ff @(posedge clk) rk_q <= rk_d;
    assign dout = dout_q;
    assign done = done_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_aes128_core.sv
// tb_aes128_core: directed FIPS-197 vectors, handshake, abort and back-to-back checks for aes128_core
module tb_aes128_core;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] din = '0;
    logic [127:0] dout;
    logic         busy, done;
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           lat, d0;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    aes128_core dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
        .key(key), .din(din), .dout(dout), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (done) n_done++;
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic launch(input logic [127:0] k, input logic [127:0] d, input logic dec);
        @(negedge clk);
        key = k;
        din = d;
        decrypt = dec;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_accept", 128'(busy), 128'd1);
    endtask
    task automatic wait_done(output int l);
        l = 0;
        do begin
            @(posedge clk);
            #1 l++;
        end while (!done && l < 60);
        check("done_seen", 128'(done), 128'd1);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        @(negedge clk) rst = 1'b0;
        // C.1 encrypt with latency and done-pulse shape
        launch(K1, P1, 1'b0);
        wait_done(lat);
        check("c1_enc_latency", 128'(lat), 128'd21);
        check("c1_enc_dout", dout, C1);
        @(posedge clk);
        #1;
        check("done_falls", 128'(done), 128'd0);
        check("busy_falls", 128'(busy), 128'd0);
        check("dout_held", dout, C1);
`ifdef AES_DECRYPT_EN
        launch(K1, C1, 1'b1);
        wait_done(lat);
        check("c1_dec_latency", 128'(lat), 128'd21);
        check("c1_dec_dout", dout, P1);
        launch(K2, C2, 1'b1);
        wait_done(lat);
        check("b_dec_dout", dout, P2);
`else
        launch(K1, P1, 1'b1);
        wait_done(lat);
        check("c1_noinv_latency", 128'(lat), 128'd21);
        check("c1_noinv_dout", dout, C1);
`endif
        launch(K2, P2, 1'b0);
        wait_done(lat);
        check("b_enc_dout", dout, C2);
        // start at cycle 5 of a running block is ignored
        d0 = n_done;
        launch(K1, P1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        key = K2;
        din = P2;
        decrypt = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("intrude_latency", 128'(lat), 128'd16);
        check("intrude_dout", dout, C1);
        // start raised in the done cycle is taken on the following edge
        key = K2;
        din = P2;
        decrypt = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", 128'(busy), 128'd1);
        check("b2b_done_low", 128'(done), 128'd0);
        wait_done(lat);
        check("b2b_latency", 128'(lat), 128'd21);
        check("b2b_dout", dout, C2);
        check("done_pulse_count", 128'(n_done - d0), 128'd2);
        // reset mid-block aborts with no done
        @(posedge clk);
        d0 = n_done;
        launch(K1, P1, 1'b0);
        repeat (13) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_dout", dout, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        @(negedge clk) rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", 128'(n_done - d0), 128'd0);
        launch(K1, P1, 1'b0);
        wait_done(lat);
        check("after_abort_latency", 128'(lat), 128'd21);
        check("after_abort_dout", dout, C1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
